dmem_bridge: RTL and testbench
==============================

// Module: dmem_bridge
// PURPOSE
//  Parametrised data-memory bridge between the CPU MEM stage and an inferred byte-lane RAM.
//  Adds what the single-word DRAM wrapper lacked:
//   - sub-word loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   - configurable base address and depth
//   - a registered read with a req/rvalid handshake
//   - misalignment detection
//   - an optional LED/switch MMIO window
// PARAMETERS
//  ADDR_BASE   32'h0000_4000  byte address of RAM word 0
//  DEPTH_WORDS 16384          RAM depth in 32-bit words (power of 2)
//  LED_W       24             LED register width (<=32)
//  SW_W        24             switch input width (<=32)
// PORTS
//  clk      in   1   system clock; all state on rising edge
//  rst      in   1   asynchronous reset, active-high
//  req      in   1   access request, sampled every cycle
//  we       in   1   1=store, 0=load (qualified by req)
//  funct3   in   3   RV32I load/store funct3 (size + sign)
//  addr     in   32  byte address
//  wdata    in   32  store data, right-aligned
//  rvalid   out  1   load data valid (one cycle after accepted load)
//  rdata    out  32  extended load data
//  misalign out  1   registered pulse: last request misaligned/out-of-range
//  led      out  LED_W LED register
//  sw       in   SW_W  asynchronous switch inputs
// BEHAVIOUR
//  Reset: rvalid=0, rdata=0, misalign=0, led=0, sync flops=0. RAM contents are not reset.
//  Handshake:
//   - Always ready; throughput 1 access/cycle; no backpressure.
//   - Load accepted at edge N -> rvalid=1 with rdata during cycle N+1; otherwise rvalid=0.
//  Address:
//   - off = addr - ADDR_BASE (32-bit wrap).
//   - In range iff off < 4*DEPTH_WORDS.
//   - word index = off[log2(4*DEPTH_WORDS)-1:2]; lane = off[1:0].
//  Alignment:
//   - H requires addr[0]=0; W requires addr[1:0]=0.
//   - Misaligned: store dropped (no byte written); load returns rvalid=1 with rdata=0.
//   - misalign=1 for exactly the following cycle.
//  Out of range (not RAM, not MMIO):
//   - Stores dropped; loads return 0.
//   - misalign=1 (doubles as access fault).
//  Stores:
//   - byte enables: SB=1<<lane, SH=3<<lane, SW=4'hF.
//   - wdata replicated across lanes (b:{4{b}}, h:{2{h}}).
//   - RAM written at the rising edge.
//  Loads:
//   - RAM read is synchronous.
//   - lane and funct3 are registered alongside the read.
//   - In the response cycle, rdata is shifted and extended: LB/LH sign-extend, LBU/LHU zero-extend.
//   - Illegal funct3 (3'b011, 3'b11x): treated as misaligned.
//  Read-after-write, same word, back-to-back: the load in cycle N+1 returns the data written at N.
//  Reset mid-operation: any pending response is discarded (rvalid=0 after release).
// CONFIGURATION
//  Macro DMEM_MMIO_EN.
//  Defined:
//   - 0xFFFF_F060: LED register, byte-lane writable. Lanes >= LED_W/8 are ignored. Reads return the LED value.
//   - 0xFFFF_F070: read-only switches, returns zero-extended sw through a 2-flop synchroniser. Stores are dropped, no fault.
//   - MMIO loads have the same 1-cycle latency and the same alignment rules.
//  Undefined:
//   - MMIO addresses are out-of-range (fault).
//   - led tied to 0; sw unused.
// STRUCTURE
//  Package dmem_pkg:
//   - funct3 localparams F3_LB..F3_SW
//   - MMIO_LED_ADDR, MMIO_SW_ADDR
//   - typedef for the registered response tag {lane, funct3, src, fault}
//  Sub-module dmem_lane_align:
//   - combinational store byte-enable/replication
//   - load shift/extension
//   - reused by the instruction-side fetch path later
//  RAM: inferred array with per-byte write enable.
// TESTING
//  1. SW 0xDEADBEEF @0x4000; LW @0x4000
//     -> rvalid next cycle, rdata=0xDEADBEEF, misalign=0.
//  2. SB 0x7F @0x4001; LB @0x4001
//     -> 0x0000007F. Memory word = 0xDEAD7FEF.
//     LBU @0x4003 -> 0x000000DE; LB @0x4003 -> 0xFFFFFFDE.
//  3. SH @0x4001 or LW @0x4002
//     -> misalign pulse 1 cycle; memory unchanged; load rdata=0.
//  4. Back-to-back SW 0x11223344 @0x4010 then LW @0x4010 next cycle
//     -> 0x11223344; 4 consecutive LWs -> 4 consecutive rvalid cycles.
//  5. DMEM_MMIO_EN, sw=24'hA5A5A5: SW 0x00C0FFEE @0xFFFFF060 -> led=0xC0FFEE.
//     LW @0xFFFFF070 (>=2 cycles after sw set) -> 0x00A5A5A5.
//     Without the macro -> misalign pulse, led=0.
//  6. Assert rst while LW response pending -> rvalid=0, led=0 immediately; RAM data intact on next LW.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bridge: funct3 codes, MMIO map, response tag.
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] MMIO_LED_ADDR = 32'hFFFF_F060;
    localparam logic [31:0] MMIO_SW_ADDR  = 32'hFFFF_F070;

    typedef enum logic [1:0] {
        SrcRam,
        SrcLed,
        SrcSw
    } src_e;

    typedef struct packed {
        logic [1:0] lane;
        logic [2:0] funct3;
        src_e       src;
        logic       fault;
    } rsp_tag_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 != 3'b011) && (f3[2:1] != 2'b11);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store enables/replication and load shift/extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_lane,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] rword,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    always_comb begin
        be        = 4'hF;
        wdata_rep = wdata;
        case (st_funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << st_lane;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << st_lane;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = rword >> {ld_lane, 3'b000};
        case (ld_funct3)
            F3_LB:   rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   rdata = shifted;
            F3_LBU:  rdata = {24'h0, shifted[7:0]};
            F3_LHU:  rdata = {16'h0, shifted[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage bridge to a byte-lane RAM with registered reads and fault reporting.
// Optional LED/switch MMIO window enabled by defining DMEM_MMIO_EN.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_4000,
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned LED_W       = 24,
    parameter int unsigned SW_W        = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             rvalid,
    output logic [31:0]      rdata,
    output logic             misalign,
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  sw
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]   off;
    logic          in_ram, hit_led, hit_sw, misaligned, fault;
    logic          load, ram_we, led_we;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   wdata_rep, rword, rdata_ext, mmio_rd;
    rsp_tag_t      tag_d, tag_q;
    logic          rvalid_q, misalign_q;
    logic [31:0]   ram_q, mmio_q;
    logic [31:0]   mem [DEPTH_WORDS];

    always_comb begin
        off    = addr - ADDR_BASE;
        in_ram = off < RAM_BYTES;
        idx    = off[AW+1:2];
        lane   = off[1:0];
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            default: misaligned = 1'b0;
        endcase
        // Out-of-range shares the misalign pulse as a generic access fault.
        fault  = !f3_legal(funct3) || misaligned || !(in_ram || hit_led || hit_sw);
        load   = req && !we;
        ram_we = req && we && !fault && in_ram;
        led_we = req && we && !fault && !in_ram && hit_led;
        tag_d  = '{lane: lane, funct3: funct3,
                   src: in_ram ? SrcRam : (hit_led ? SrcLed : SrcSw), fault: fault};
    end

    dmem_lane_align u_align (
        .st_funct3 (funct3),
        .st_lane   (lane),
        .wdata     (wdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .ld_funct3 (tag_q.funct3),
        .ld_lane   (tag_q.lane),
        .rword     (rword),
        .rdata     (rdata_ext)
    );

`ifdef DMEM_MMIO_EN
    logic [LED_W-1:0] led_q;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;

    assign hit_led = addr[31:2] == MMIO_LED_ADDR[31:2];
    assign hit_sw  = addr[31:2] == MMIO_SW_ADDR[31:2];
    assign mmio_rd = hit_led ? 32'(led_q) : 32'(sw_sync_q);
    assign led     = led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            // Lanes above the register width are silently ignored.
            for (int b = 0; b < int'(LED_W / 8); b++) begin
                if (led_we && be[b]) led_q[8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end
`else
    logic unused_sw;
    logic unused_led_we;

    assign hit_led       = 1'b0;
    assign hit_sw        = 1'b0;
    assign mmio_rd       = '0;
    assign led           = '0;
    assign unused_sw     = ^sw;
    assign unused_led_we = led_we;
`endif

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
        if (load) ram_q <= mem[idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            tag_q      <= '0;
            mmio_q     <= '0;
        end else begin
            rvalid_q   <= load;
            misalign_q <= req && fault;
            if (load) begin
                tag_q  <= tag_d;
                mmio_q <= mmio_rd;
            end
        end
    end

    assign rword    = (tag_q.src == SrcRam) ? ram_q : mmio_q;
    assign rvalid   = rvalid_q;
    assign rdata    = (rvalid_q && !tag_q.fault) ? rdata_ext : '0;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: byte-array reference model, randomized traffic.
module tb_dmem_bridge;

    localparam logic [31:0] BASE   = 32'h0000_4000;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned BYTES  = DEPTH * 4;
    localparam int unsigned LED_W  = 24;
    localparam int unsigned SW_W   = 24;
    localparam logic [31:0] LED_A  = 32'hFFFF_F060;
    localparam logic [31:0] SW_A   = 32'hFFFF_F070;
`ifdef DMEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req = 1'b0;
    logic             we = 1'b0;
    logic [2:0]       funct3 = '0;
    logic [31:0]      addr = '0;
    logic [31:0]      wdata = '0;
    logic             rvalid;
    logic [31:0]      rdata;
    logic             misalign;
    logic [LED_W-1:0] led;
    logic [SW_W-1:0]  sw = 24'hA5A5A5;

    dmem_bridge #(
        .ADDR_BASE   (BASE),
        .DEPTH_WORDS (DEPTH),
        .LED_W       (LED_W),
        .SW_W        (SW_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .misalign (misalign),
        .led      (led),
        .sw       (sw)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t             ldq[$];
    exp_t             misq[$];
    logic [7:0]       mem_m [BYTES];
    logic [LED_W-1:0] led_m = '0;
    int               cyc = 0;
    int               n_tests = 0;
    int               n_fail = 0;
    bit               mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: memory is a flat byte array, accesses are n consecutive bytes.
    function automatic void predict(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] d, output logic flt,
                                    output logic [31:0] rd);
        int          n;
        logic [31:0] off, mword, v;
        logic        legal, in_ram, is_led, is_sw;
        logic [7:0]  b;
        int          ln;
        n      = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        off    = a - BASE;
        in_ram = off < BYTES;
        is_led = MMIO && ((a >> 2) == (LED_A >> 2));
        is_sw  = MMIO && ((a >> 2) == (SW_A >> 2));
        flt    = !legal || ((a % n) != 0) || !(in_ram || is_led || is_sw);
        rd     = '0;
        if (flt) return;
        mword = is_led ? 32'(led_m) : 32'(sw);
        v     = '0;
        for (int i = 0; i < n; i++) begin
            ln = int'(a % 4) + i;
            if (w) begin
                b = d[8*i +: 8];
                if (in_ram) mem_m[off + i] = b;
                else if (is_led && ln < int'(LED_W / 8)) led_m[8*ln +: 8] = b;
            end else begin
                b = in_ram ? mem_m[off + i] : mword[8*ln +: 8];
                v = v | (32'(b) << (8 * i));
            end
        end
        if (!w && !f3[2]) begin
            if (n == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (n == 2 && v[15]) v = v | 32'hFFFF_0000;
        end
        rd = v;
    endfunction

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        logic        flt;
        logic [31:0] rd;
        @(negedge clk);
        predict(w, f3, a, d, flt, rd);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
        misq.push_back('{cyc: cyc, val: {31'd0, flt}});
        if (!w) ldq.push_back('{cyc: cyc, val: rd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 1'b0; we = 1'b0;
        end
    endtask

    // Monitor: compares whatever the DUT presents against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        logic exp_mis;
        if (mon_en) begin
            exp_mis = 1'b0;
            if (misq.size() > 0 && misq[0].cyc == cyc - 1) begin
                e       = misq.pop_front();
                exp_mis = e.val[0];
            end
            check("misalign", {31'd0, misalign}, {31'd0, exp_mis});
            if (rvalid) begin
                if (ldq.size() > 0 && ldq[0].cyc == cyc - 1) begin
                    e = ldq.pop_front();
                    check("rdata", rdata, e.val);
                end else begin
                    check("unexpected_rvalid", 32'd1, 32'd0);
                end
            end else if (ldq.size() > 0 && ldq[0].cyc == cyc - 1) begin
                void'(ldq.pop_front());
                check("missing_rvalid", 32'd0, 32'd1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rvalid", {31'd0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_misalign", {31'd0, misalign}, 32'd0);
        check("reset_led", 32'(led), 32'd0);
        @(posedge clk);
        #1 mon_en = 1'b1;

        for (int i = 0; i < int'(DEPTH); i++) issue(1'b1, 3'b010, BASE + 32'(4 * i), $urandom);

        issue(1'b1, 3'b010, 32'h4000, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h4000, 32'h0);
        issue(1'b1, 3'b000, 32'h4001, 32'h0000_007F);
        issue(1'b0, 3'b000, 32'h4001, 32'h0);
        issue(1'b0, 3'b010, 32'h4000, 32'h0);
        issue(1'b0, 3'b100, 32'h4003, 32'h0);
        issue(1'b0, 3'b000, 32'h4003, 32'h0);
        issue(1'b1, 3'b001, 32'h4001, 32'hFFFF_FFFF);
        issue(1'b0, 3'b010, 32'h4002, 32'h0);
        issue(1'b0, 3'b010, 32'h4000, 32'h0);
        issue(1'b1, 3'b010, 32'h4010, 32'h1122_3344);
        for (int i = 0; i < 4; i++) issue(1'b0, 3'b010, 32'h4010, 32'h0);
        issue(1'b0, 3'b010, BASE + BYTES - 4, 32'h0);
        issue(1'b0, 3'b010, BASE + BYTES, 32'h0);
        issue(1'b1, 3'b010, BASE - 4, 32'h1234_5678);
        issue(1'b0, 3'b011, 32'h4000, 32'h0);

        issue(1'b1, 3'b010, LED_A, 32'h00C0_FFEE);
        idle(1);
        check("led_after_sw", 32'(led), 32'(led_m));
        issue(1'b0, 3'b010, SW_A, 32'h0);
        issue(1'b0, 3'b010, LED_A, 32'h0);
        issue(1'b1, 3'b000, LED_A + 3, 32'h55);
        idle(1);
        check("led_lane3", 32'(led), 32'(led_m));

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                r = $urandom_range(0, 9);
                if (r <= 5)      a = BASE + $urandom_range(0, BYTES - 1);
                else if (r == 6) a = BASE + BYTES - 4 + $urandom_range(0, 7);
                else if (r == 7) a = BASE - $urandom_range(1, 8);
                else if (r == 8) a = LED_A + $urandom_range(0, 3);
                else             a = SW_A + $urandom_range(0, 3);
                if ($urandom_range(0, 9) < 7) begin
                    r  = $urandom_range(0, 4);
                    f3 = (r == 3) ? 3'b100 : (r == 4) ? 3'b101 : 3'(r);
                end else begin
                    f3 = 3'($urandom_range(0, 7));
                end
                issue(1'($urandom_range(0, 1)), f3, a, $urandom);
            end
        end
        idle(3);
        check("led_final", 32'(led), 32'(led_m));
        check("drain_loads", 32'(ldq.size()), 32'd0);

        @(posedge clk);
        #1 mon_en = 1'b0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h4010;
        @(posedge clk);
        #2 rst = 1'b1;
        req = 1'b0;
        #1;
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        led_m = '0;
        @(negedge clk);
        rst = 1'b0;
        ldq.delete();
        misq.delete();
        @(posedge clk);
        #1 mon_en = 1'b1;
        issue(1'b0, 3'b010, 32'h4010, 32'h0);
        issue(1'b0, 3'b010, 32'h4000, 32'h0);
        idle(3);
        check("drain_after_rst", 32'(ldq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
